// File: rtl/arith_pkg.sv
// Shared opcodes and FSM state encodings for seq_arith_unit.
package arith_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative LSB-first shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done flags the final cycle; product then already includes the last partial product.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_shift;
  logic [WIDTH-1:0]   b_shift;

  assign busy = (cnt != '0);
  assign done = (cnt == CW'(1));

  // Look-ahead sum so the caller can capture the full product on the last cycle.
  assign product = acc + (b_shift[0] ? a_shift : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      a_shift <= '0;
      b_shift <= '0;
    end else if (start) begin
      cnt     <= CW'(WIDTH);
      acc     <= '0;
      a_shift <= {{WIDTH{1'b0}}, a};
      b_shift <= b;
    end else if (busy) begin
      cnt     <= cnt - CW'(1);
      acc     <= product;
      a_shift <= a_shift << 1;
      b_shift <= b_shift >> 1;
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked MUL/SUB unit: SUB or err result 1 cycle after accept, MUL WIDTH+1 cycles.
// Accepts only in IDLE; a held result stalls indefinitely until out_ready.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ENABLE_MUL = 1,
  parameter int ENABLE_SUB = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               borrow,
  output logic               err
);

  state_t             state;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   diff;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign diff      = a - b;

  generate
    if (ENABLE_MUL != 0) begin : g_mul
      shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      borrow    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if ((op == OP_SUB) && (ENABLE_SUB != 0)) begin
              res       <= {{WIDTH{1'b0}}, diff};
              borrow    <= (a < b);
              err       <= 1'b0;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else if ((op == OP_MUL) && (ENABLE_MUL != 0)) begin
              state <= ST_MUL;
            end else begin
              res       <= '0;
              borrow    <= 1'b0;
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (mul_busy && mul_done) begin
            res       <= mul_product;
            borrow    <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
